// File: rtl/lamp_seq_checker_pkg.sv
// lamp_seq_checker_pkg: shared state encoding, error cause codes and lamp bit indices
package lamp_seq_checker_pkg;
    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        RED    = 3'd1,
        GREEN  = 3'd2,
        YELLOW = 3'd3
    } state_t;

    localparam logic [1:0] E_NONE    = 2'd0;
    localparam logic [1:0] E_ILLEGAL = 2'd1;
    localparam logic [1:0] E_ORDER   = 2'd2;
    localparam logic [1:0] E_DWELL   = 2'd3;

    localparam int R_IDX = 0;
    localparam int G_IDX = 1;
    localparam int Y_IDX = 2;
endpackage

// File: rtl/lamp_seq_checker.sv
// lamp_seq_checker: watches a R->G->Y lamp code, checks order and dwell, counts full cycles
// Ports: clk, rst (async high); light[0:2] = R,G,Y lamp code; clr clears err/err_code/cycle_cnt;
//        state = checker FSM state; err sticky violation flag; err_code first cause; cycle_cnt saturating
module lamp_seq_checker
    import lamp_seq_checker_pkg::*;
#(
    parameter int R_DWELL = 1,
    parameter int G_DWELL = 1,
    parameter int Y_DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:2] light,
    input  logic       clr,
    output logic [2:0] state,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] cycle_cnt
);
    state_t     cur, nxt, s;
    logic [7:0] dwell, dwell_n, dinc, exp_d;
    logic       full, full_n, inc;
    logic [1:0] ecode;

    function automatic logic onehot(input logic [0:2] l);
        return $onehot(l);
    endfunction

    function automatic state_t next_colour(input state_t c);
        return c == RED ? GREEN : c == GREEN ? YELLOW : RED;
    endfunction

    function automatic state_t colour_of(input logic [0:2] l);
        return l[R_IDX] ? RED : l[G_IDX] ? GREEN : YELLOW;
    endfunction

    assign s     = colour_of(light);
    assign dinc  = dwell == 8'hff ? dwell : dwell + 8'd1;
    assign exp_d = cur == RED ? 8'(R_DWELL) : cur == GREEN ? 8'(G_DWELL) : 8'(Y_DWELL);
    assign state = cur;

    // full marks that the current cycle began with a Y->R entry, so its closing Y->R is a whole cycle
    always_comb begin
        nxt     = cur;
        dwell_n = dwell;
        full_n  = full;
        ecode   = E_NONE;
        inc     = 1'b0;
        if (cur == SYNC) begin
            if (onehot(light)) begin
                nxt     = s;
                dwell_n = 8'd1;
                full_n  = 1'b0;
            end
        end else if (!onehot(light)) begin
            ecode = E_ILLEGAL;
        end else if (s == cur) begin
            dwell_n = dinc;
            ecode   = dinc > exp_d ? E_DWELL : E_NONE;
        end else if (s == next_colour(cur)) begin
            if (dwell == exp_d) begin
                nxt     = s;
                dwell_n = 8'd1;
                inc     = cur == YELLOW && full;
                full_n  = cur == YELLOW ? 1'b1 : full;
            end else begin
                ecode = E_DWELL;
            end
        end else begin
            ecode = E_ORDER;
        end
        if (ecode != E_NONE) begin
            nxt     = SYNC;
            dwell_n = 8'd0;
            full_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= SYNC;
            dwell     <= 8'd0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= E_NONE;
            cycle_cnt <= 8'd0;
        end else begin
            cur   <= nxt;
            dwell <= dwell_n;
            full  <= full_n;
            if (clr) begin
                err       <= 1'b0;
                err_code  <= E_NONE;
                cycle_cnt <= 8'd0;
            end else begin
                if (ecode != E_NONE) begin
                    err      <= 1'b1;
                    err_code <= err ? err_code : ecode;
                end
                if (inc && cycle_cnt != 8'hff)
                    cycle_cnt <= cycle_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_lamp_seq_checker.sv
// tb_lamp_seq_checker: scoreboard bench for two checker instances (default dwells, and green dwell 2)
module tb_lamp_seq_checker;
    import lamp_seq_checker_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic [0:2] l1 = 3'b000, l2 = 3'b000;
    logic [2:0] st1, st2;
    logic       e1, e2;
    logic [1:0] c1, c2;
    logic [7:0] n1, n2;

    always #5 clk = ~clk;

    lamp_seq_checker u1 (
        .clk(clk), .rst(rst), .light(l1), .clr(clr),
        .state(st1), .err(e1), .err_code(c1), .cycle_cnt(n1)
    );

    lamp_seq_checker #(.G_DWELL(2)) u2 (
        .clk(clk), .rst(rst), .light(l2), .clr(clr),
        .state(st2), .err(e2), .err_code(c2), .cycle_cnt(n2)
    );

    typedef struct {
        bit sync;
        int c;
        int n;
        int yr;
        bit err;
        int code;
        int cnt;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t q[$];
    mdl_t m1, m2;
    int   errors = 0, checks = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.sync = 1; m.c = 0; m.n = 0; m.yr = 0; m.err = 0; m.code = 0; m.cnt = 0;
        return m;
    endfunction

    // colour index 0=R 1=G 2=Y; yr counts Y->R entries since the last resync
    function automatic mdl_t step(input mdl_t mi, input logic [0:2] l, input bit cl, input int gd);
        mdl_t m;
        int   col, e, lim;
        m   = mi;
        e   = 0;
        col = l[0] ? 0 : l[1] ? 1 : 2;
        lim = m.c == 1 ? gd : 1;
        if (m.sync) begin
            if ($countones(l) == 1) begin
                m.sync = 0; m.c = col; m.n = 1;
            end
        end else if ($countones(l) != 1) e = 1;
        else if (col == m.c) begin
            m.n = m.n < 255 ? m.n + 1 : 255;
            if (m.n > lim) e = 3;
        end else if (col == (m.c + 1) % 3) begin
            if (m.n == lim) begin
                if (m.c == 2) begin
                    if (m.yr > 0 && m.cnt < 255) m.cnt++;
                    m.yr++;
                end
                m.c = col; m.n = 1;
            end else e = 3;
        end else e = 2;
        if (e != 0) begin
            m.sync = 1; m.yr = 0;
            if (!m.err) m.code = e;
            m.err = 1;
        end
        if (cl) begin
            m.err = 0; m.code = 0; m.cnt = 0;
        end
        return m;
    endfunction

    function automatic logic [0:2] gen(input mdl_t m, input int gd, input bit chaos);
        int         r, lim, k;
        logic [0:2] l;
        r   = int'($urandom_range(0, 99));
        k   = int'($urandom_range(0, 2));
        lim = m.c == 1 ? gd : 1;
        l   = 3'b000;
        if (chaos && r < 5) l = 3'($urandom_range(0, 7));
        else if (chaos && r < 9) l[(m.c + 2) % 3] = 1'b1;
        else if (m.sync) l[k] = 1'b1;
        else if (m.n < lim || (chaos && r < 13)) l[m.c] = 1'b1;
        else l[(m.c + 1) % 3] = 1'b1;
        return l;
    endfunction

    function automatic int stof(input mdl_t m);
        return m.sync ? int'(SYNC) : m.c == 0 ? int'(RED) : m.c == 1 ? int'(GREEN) : int'(YELLOW);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [0:2] a, input logic [0:2] b, input bit cl);
        exp_t x;
        @(negedge clk);
        l1  = a;
        l2  = b;
        clr = cl;
        m1  = step(m1, a, cl, 1);
        m2  = step(m2, b, cl, 2);
        x.a = m1;
        x.b = m2;
        q.push_back(x);
    endtask

    task automatic all_zero(input string nm);
        chk({nm, "_st1"}, int'(st1), int'(SYNC));
        chk({nm, "_st2"}, int'(st2), int'(SYNC));
        chk({nm, "_err1"}, int'(e1), 0);
        chk({nm, "_err2"}, int'(e2), 0);
        chk({nm, "_code1"}, int'(c1), 0);
        chk({nm, "_code2"}, int'(c2), 0);
        chk({nm, "_cnt1"}, int'(n1), 0);
        chk({nm, "_cnt2"}, int'(n2), 0);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("sb_state1", int'(st1), stof(x.a));
            chk("sb_err1", int'(e1), int'(x.a.err));
            chk("sb_code1", int'(c1), x.a.code);
            chk("sb_cnt1", int'(n1), x.a.cnt);
            chk("sb_state2", int'(st2), stof(x.b));
            chk("sb_err2", int'(e2), int'(x.b.err));
            chk("sb_code2", int'(c2), x.b.code);
            chk("sb_cnt2", int'(n2), x.b.cnt);
        end
    end

    initial begin
        m1 = mreset();
        m2 = mreset();
        #12;
        all_zero("reset");
        rst = 1'b0;

        repeat (10) begin
            cyc(3'b100, 3'b000, 0);
            cyc(3'b010, 3'b000, 0);
            cyc(3'b001, 3'b000, 0);
        end
        cyc(3'b100, 3'b000, 0);
        #6;
        chk("ten_rounds_cnt", int'(n1), 9);
        chk("ten_rounds_err", int'(e1), 0);

        cyc(gen(m1, 1, 0), 3'b100, 0);
        cyc(gen(m1, 1, 0), 3'b010, 0);
        cyc(gen(m1, 1, 0), 3'b010, 0);
        cyc(gen(m1, 1, 0), 3'b010, 0);
        #6;
        chk("gdwell_state", int'(st2), int'(SYNC));
        chk("gdwell_err", int'(e2), 1);
        chk("gdwell_code", int'(c2), 3);

        cyc(3'b110, gen(m2, 2, 0), 0);
        #6;
        chk("illegal_code", int'(c1), 1);
        chk("illegal_err", int'(e1), 1);
        cyc(3'b100, gen(m2, 2, 0), 0);
        #6;
        chk("resync_state", int'(st1), int'(RED));
        cyc(3'b010, gen(m2, 2, 0), 0);
        cyc(3'b001, gen(m2, 2, 0), 0);
        cyc(3'b100, gen(m2, 2, 0), 1);
        #6;
        chk("clr_err", int'(e1), 0);
        chk("clr_code", int'(c1), 0);
        chk("clr_cnt", int'(n1), 0);
        chk("clr_keeps_state", int'(st1), int'(RED));
        cyc(3'b010, gen(m2, 2, 0), 0);
        #6;
        chk("pre_pulse_green", int'(st1), int'(GREEN));
        #1 rst = 1'b1;
        #1 all_zero("async_rst");
        rst = 1'b0;
        m1 = mreset();
        m2 = mreset();

        cyc(3'b100, gen(m2, 2, 0), 0);
        cyc(3'b001, gen(m2, 2, 0), 0);
        #6;
        chk("order_err", int'(e1), 1);
        chk("order_code", int'(c1), 2);
        cyc(3'b110, gen(m2, 2, 0), 0);
        #6;
        chk("first_code_kept", int'(c1), 2);

        cyc(3'b000, gen(m2, 2, 0), 1);
        repeat (300) begin
            cyc(3'b100, gen(m2, 2, 0), 0);
            cyc(3'b010, gen(m2, 2, 0), 0);
            cyc(3'b001, gen(m2, 2, 0), 0);
        end
        cyc(3'b100, gen(m2, 2, 0), 0);
        #6;
        chk("sat_cnt", int'(n1), 255);
        chk("sat_err", int'(e1), 0);

        repeat (1500) cyc(gen(m1, 1, 1), gen(m2, 2, 1), $urandom_range(0, 99) < 3);

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
